// File: rtl/uart_pkg.sv
// Shared types for the UART receive path.
// Receiver FSM states and parity mode encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO holding received frames.
// Pointers carry a wrap bit; a push into a full FIFO succeeds only with a pop.
module uart_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // Pointer next-state
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  // Pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage, cleared so the head reads zero after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_top.sv
// UART receiver with frame/parity checking and an output FIFO.
// Samples mid-bit; errored frames are still queued with their flags.
module uart_rx_fifo_top
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 cs_n,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_parity_err,
  output logic                 m_frame_err,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 done,
  output logic                 overrun,
  input  logic                 ovr_clr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int FW = DATA_BITS + 2;

  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 sync1_q, rxs;
  logic                 done_q;
  logic                 ovr_q, ovr_d;
  logic                 push;
  logic                 ferr;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic [FW-1:0]        head;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs     <= sync1_q;
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state: bit timing, shifting and parity evaluation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rxs && !cs_n) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          perr_d  = 1'b0;
          state_d = rxs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST)
            state_d = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          perr_d  = (PARITY == PAR_ODD) ? ~(^shift_q ^ rxs)
                                        : (^shift_q ^ rxs);
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Outputs: push the frame on the stop-bit sample
  always_comb begin
    push = 1'b0;
    ferr = 1'b0;
    if (state_q == RX_STOP && cnt_q == CNT_FULL) begin
      push = 1'b1;
      ferr = ~rxs;
    end
  end

  assign pop = m_valid & m_ready;

  // Sticky overrun: a drop outranks a clear
  always_comb begin
    ovr_d = ovr_q;
    if (push && fifo_full && !pop) ovr_d = 1'b1;
    else if (ovr_clr)              ovr_d = 1'b0;
  end

  // Registered done pulse and overrun flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      done_q <= push;
      ovr_q  <= ovr_d;
    end
  end

  uart_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   ({ferr, perr_q, shift_q}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m_valid      = ~fifo_empty;
  assign m_data       = head[DATA_BITS-1:0];
  assign m_parity_err = head[DATA_BITS];
  assign m_frame_err  = head[DATA_BITS+1];
  assign done         = done_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo_top.sv
// Directed bench for uart_rx_fifo_top.
// 16 clocks per bit, 8 data bits, even parity, 4-entry FIFO.
module tb_uart_rx_fifo_top;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       cs_n;
  logic [7:0] m_data;
  logic       m_parity_err;
  logic       m_frame_err;
  logic       m_valid;
  logic       m_ready;
  logic       done;
  logic       overrun;
  logic       ovr_clr;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int vld_cnt = 0;
  int d0;
  int v0;
  logic [9:0] cap_q [$];
  logic [9:0] e;

  uart_rx_fifo_top #(
    .CLKS_PER_BIT (16),
    .DATA_BITS    (8),
    .PARITY       (1),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .cs_n         (cs_n),
    .m_data       (m_data),
    .m_parity_err (m_parity_err),
    .m_frame_err  (m_frame_err),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .done         (done),
    .overrun      (overrun),
    .ovr_clr      (ovr_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (m_valid) vld_cnt++;
    if (m_valid && m_ready)
      cap_q.push_back({m_frame_err, m_parity_err, m_data});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic take(output logic [9:0] v);
    if (cap_q.size() > 0) v = cap_q.pop_front();
    else v = 10'bx;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pb,
                            input logic sb);
    rx = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) tick();
    end
    rx = pb;
    repeat (16) tick();
    rx = sb;
    repeat (16) tick();
    rx = 1'b1;
    repeat (24) tick();
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    cs_n = 1'b0;
    m_ready = 1'b1;
    ovr_clr = 1'b0;
    repeat (3) tick();
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_data", m_data, 8'h00);
    chk("rst_done", done, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_flags", {m_frame_err, m_parity_err}, 2'b00);
    reset = 1'b0;
    repeat (3) tick();

    // 1: clean frame, consumer ready
    d0 = done_cnt;
    v0 = vld_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_vcyc", vld_cnt - v0, 1);
    chk("t1_n", cap_q.size(), 1);
    take(e);
    chk("t1_entry", e, {2'b00, 8'hA5});
    chk("t1_valid", m_valid, 1'b0);

    // 2: false start
    d0 = done_cnt;
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (30) tick();
    chk("t2_done", done_cnt - d0, 0);
    chk("t2_valid", m_valid, 1'b0);

    // 3: deselected
    cs_n = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b1);
    chk("t3_done", done_cnt - d0, 0);
    chk("t3_valid", m_valid, 1'b0);
    cs_n = 1'b0;

    // 4: parity error then frame error
    send_frame(8'h81, 1'b1, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0);
    chk("t4_done", done_cnt - d0, 2);
    chk("t4_n", cap_q.size(), 2);
    take(e);
    chk("t4_perr", e, {2'b01, 8'h81});
    take(e);
    chk("t4_ferr", e, {2'b10, 8'h55});

    // 5: fill, overrun, drain, clear
    m_ready = 1'b0;
    d0 = done_cnt;
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h02, 1'b1, 1'b1);
    send_frame(8'h03, 1'b0, 1'b1);
    send_frame(8'h04, 1'b1, 1'b1);
    chk("t5_ovr_pre", overrun, 1'b0);
    send_frame(8'h05, 1'b0, 1'b1);
    chk("t5_done", done_cnt - d0, 5);
    chk("t5_ovr", overrun, 1'b1);
    chk("t5_valid", m_valid, 1'b1);
    repeat (5) tick();
    chk("t5_hold", {m_frame_err, m_parity_err, m_data}, {2'b00, 8'h01});
    cap_q.delete();
    m_ready = 1'b1;
    repeat (8) tick();
    chk("t5_n", cap_q.size(), 4);
    for (int i = 1; i <= 4; i++) begin
      take(e);
      chk($sformatf("t5_pop%0d", i), e, {2'b00, 8'(i)});
    end
    chk("t5_empty", m_valid, 1'b0);
    chk("t5_sticky", overrun, 1'b1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    tick();
    chk("t5_clr", overrun, 1'b0);

    // 6: reset mid-frame flushes and recovers
    m_ready = 1'b0;
    send_frame(8'h33, 1'b0, 1'b1);
    chk("t6_pre", m_valid, 1'b1);
    d0 = done_cnt;
    rx = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 3; i++) begin
      rx = (8'h12 >> i) & 8'h01;
      repeat (16) tick();
    end
    reset = 1'b1;
    repeat (2) tick();
    rx = 1'b1;
    reset = 1'b0;
    repeat (200) tick();
    chk("t6_valid", m_valid, 1'b0);
    chk("t6_done", done_cnt - d0, 0);
    chk("t6_data", m_data, 8'h00);
    cap_q.delete();
    m_ready = 1'b1;
    send_frame(8'h7E, 1'b0, 1'b1);
    chk("t6_done2", done_cnt - d0, 1);
    chk("t6_n", cap_q.size(), 1);
    take(e);
    chk("t6_entry", e, {2'b00, 8'h7E});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
